dwt_col_lift53: RTL and testbench

Vertical (column) 5/3 reversible integer lifting filter for the DWT datapath. Consumes one column as a stream of even/odd sample pairs and emits one low-pass/high-pass coefficient pair per input pair. Outputs drive `col_ldata`/`col_hdata`/`col_out_vld` directly into the transpose stage. Symmetric extension is applied at both column ends.

---
 rtl/dwt_col_lift53.sv | 129 ++++++++++++
 tb/tb_dwt_col_lift53.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dwt_col_lift53.sv
// Vertical 5/3 reversible lifting filter: one L/H coefficient pair per input even/odd pair, symmetric extension at both column ends.
// Optional output saturation to 16 bits is enabled by defining DWT_COL_SAT_EN; otherwise outputs wrap.
module dwt_col_lift53 #(
    parameter int IW = 12
) (
    input  logic                 clk_tr,
    input  logic                 rst,
    input  logic                 dwt_work,
    input  logic signed [IW-1:0] col_in_even,
    input  logic signed [IW-1:0] col_in_odd,
    input  logic                 col_in_vld,
    input  logic                 col_in_last,
    output logic                 col_in_rdy,
    output logic signed [15:0]   col_ldata,
    output logic signed [15:0]   col_hdata,
    output logic                 col_out_vld
);

    localparam int AW = IW + 3;
    localparam int EW = (AW > 16) ? AW : 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        HOLD  = 2'd1,
        FLUSH = 2'd2
    } state_t;

    state_t                state, state_n;
    logic signed [IW-1:0]  e_q, o_q;
    logic signed [AW-1:0]  dprev_q;
    logic                  first_q;

    logic signed [IW-1:0]  x_next;
    logic signed [AW-1:0]  d_cur, dp_sel, s_cur;
    logic                  accept, emit, load;

    function automatic logic signed [AW-1:0] lift_d(input logic signed [IW-1:0] e,
                                                    input logic signed [IW-1:0] o,
                                                    input logic signed [IW-1:0] en);
        logic signed [AW-1:0] sum;
        sum = AW'(e) + AW'(en);
        return AW'(o) - (sum >>> 1);
    endfunction

    function automatic logic signed [AW-1:0] lift_s(input logic signed [IW-1:0] e,
                                                    input logic signed [AW-1:0] dp,
                                                    input logic signed [AW-1:0] d);
        logic signed [AW-1:0] acc;
        acc = dp + d + AW'(2);
        return AW'(e) + (acc >>> 2);
    endfunction

    // Internal results are narrowed to the 16-bit output bus here, clamped or wrapped.
    function automatic logic signed [15:0] to_out(input logic signed [AW-1:0] v);
        logic signed [EW-1:0] x;
        x = EW'(v);
`ifdef DWT_COL_SAT_EN
        if (x > EW'(32767))
            return 16'sh7fff;
        if (x < EW'(-32768))
            return 16'sh8000;
`endif
        return 16'(x);
    endfunction

    assign col_in_rdy = dwt_work & (state != FLUSH);
    assign accept     = col_in_vld & col_in_rdy;

    // In FLUSH the right neighbour is the mirrored even sample of the held pair.
    assign x_next = (state == FLUSH) ? e_q : col_in_even;
    assign d_cur  = lift_d(e_q, o_q, x_next);
    assign dp_sel = first_q ? d_cur : dprev_q;
    assign s_cur  = lift_s(e_q, dp_sel, d_cur);

    always_comb begin
        state_n = state;
        emit    = 1'b0;
        load    = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    load    = 1'b1;
                    state_n = col_in_last ? FLUSH : HOLD;
                end
            end
            HOLD: begin
                if (accept) begin
                    emit    = 1'b1;
                    load    = 1'b1;
                    state_n = col_in_last ? FLUSH : HOLD;
                end
            end
            FLUSH: begin
                if (dwt_work) begin
                    emit    = 1'b1;
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk_tr) begin
        if (rst) begin
            state       <= IDLE;
            e_q         <= '0;
            o_q         <= '0;
            dprev_q     <= '0;
            first_q     <= 1'b0;
            col_ldata   <= '0;
            col_hdata   <= '0;
            col_out_vld <= 1'b0;
        end else if (dwt_work) begin
            state       <= state_n;
            col_out_vld <= emit;
            if (emit) begin
                col_ldata <= to_out(s_cur);
                col_hdata <= to_out(d_cur);
                dprev_q   <= d_cur;
            end
            if (load) begin
                e_q     <= col_in_even;
                o_q     <= col_in_odd;
                first_q <= (state == IDLE);
            end
        end
    end

endmodule

// File: tb/tb_dwt_col_lift53.sv
// Scoreboard bench for dwt_col_lift53: a column-level reference model queues expected L/H pairs, a monitor pops them on each emission.
module tb_dwt_col_lift53;

    localparam int IW = 16;

    logic                 clk_tr   = 1'b0;
    logic                 rst      = 1'b1;
    logic                 dwt_work = 1'b1;
    logic signed [IW-1:0] col_in_even = '0;
    logic signed [IW-1:0] col_in_odd  = '0;
    logic                 col_in_vld  = 1'b0;
    logic                 col_in_last = 1'b0;
    logic                 col_in_rdy;
    logic signed [15:0]   col_ldata, col_hdata;
    logic                 col_out_vld;

    typedef struct {
        int l;
        int h;
    } pair_t;

    pair_t  exp_q[$];
    longint emit_t[$];
    int     n_checks = 0;
    int     n_fail   = 0;
    bit     stall_en = 1'b0;
    int     held_l = 0, held_h = 0, held_v = 0;

    dwt_col_lift53 #(.IW(IW)) dut (
        .clk_tr     (clk_tr),
        .rst        (rst),
        .dwt_work   (dwt_work),
        .col_in_even(col_in_even),
        .col_in_odd (col_in_odd),
        .col_in_vld (col_in_vld),
        .col_in_last(col_in_last),
        .col_in_rdy (col_in_rdy),
        .col_ldata  (col_ldata),
        .col_hdata  (col_hdata),
        .col_out_vld(col_out_vld)
    );

    always #5 clk_tr = ~clk_tr;

    function automatic void chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endfunction

    function automatic int fit16(input int v);
`ifdef DWT_COL_SAT_EN
        if (v > 32767) return 32767;
        if (v < -32768) return -32768;
        return v;
`else
        logic [15:0] w;
        w = v[15:0];
        return int'($signed(w));
`endif
    endfunction

    // Whole-column reference: d from odd samples, then s from neighbouring d, mirrored at both ends.
    function automatic void push_col(input int x[$], input int npush);
        int n;
        int d[$];
        int en, dp, s;
        n = x.size() / 2;
        for (int k = 0; k < n; k++) begin
            en = (k < n - 1) ? x[2*k+2] : x[2*n-2];
            d.push_back(x[2*k+1] - ((x[2*k] + en) >>> 1));
        end
        for (int k = 0; k < npush; k++) begin
            dp = (k == 0) ? d[0] : d[k-1];
            s  = x[2*k] + ((dp + d[k] + 2) >>> 2);
            exp_q.push_back('{fit16(s), fit16(d[k])});
        end
    endfunction

    task automatic send_pair(input int e, input int o, input bit last, output longint t);
        int guard;
        guard = 0;
        @(negedge clk_tr);
        col_in_even = 16'(e);
        col_in_odd  = 16'(o);
        col_in_last = last;
        col_in_vld  = 1'b1;
        forever begin
            #4;
            if (col_in_rdy) break;
            @(negedge clk_tr);
            guard++;
            if (guard > 300) begin
                $display("FAIL send_timeout: col_in_rdy got %0d, expected 1", col_in_rdy);
                $fatal(1, "input never accepted");
            end
        end
        @(posedge clk_tr);
        t = $time;
        #1;
        col_in_vld  = 1'b0;
        col_in_last = 1'b0;
    endtask

    task automatic send_col(input int x[$], input int gap_max, output longint t0);
        int n;
        longint t;
        n  = x.size() / 2;
        t0 = 0;
        push_col(x, n);
        for (int k = 0; k < n; k++) begin
            send_pair(x[2*k], x[2*k+1], (k == n - 1), t);
            if (k == 0) t0 = t;
            repeat ($urandom_range(0, gap_max)) @(negedge clk_tr);
        end
    endtask

    task automatic wait_drain();
        int g;
        g = 0;
        while (exp_q.size() != 0 && g < 500) begin
            @(negedge clk_tr);
            g++;
        end
        chk("drain_empty", exp_q.size(), 0);
    endtask

    initial begin
        forever begin
            @(negedge clk_tr);
            if (stall_en) dwt_work = ($urandom_range(0, 3) != 0);
        end
    end

    // Monitor: an emission is a high vld after an edge at which the DUT was enabled.
    initial begin
        longint t;
        bit     w, r;
        pair_t  p;
        forever begin
            @(posedge clk_tr);
            t = $time;
            w = dwt_work;
            r = rst;
            #1;
            if (r) begin
                chk("rst_ldata", col_ldata, 0);
                chk("rst_hdata", col_hdata, 0);
                chk("rst_vld", col_out_vld, 0);
                held_l = 0; held_h = 0; held_v = 0;
            end else if (w) begin
                if (col_out_vld) begin
                    emit_t.push_back(t);
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_out: got L=%0d H=%0d, expected no output", col_ldata, col_hdata);
                    end else begin
                        p = exp_q.pop_front();
                        chk("L", col_ldata, p.l);
                        chk("H", col_hdata, p.h);
                    end
                end
                held_l = col_ldata; held_h = col_hdata; held_v = col_out_vld;
            end else begin
                chk("stall_hold_l", col_ldata, held_l);
                chk("stall_hold_h", col_hdata, held_h);
                chk("stall_hold_vld", col_out_vld, held_v);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time exceeded");
        $fatal(1, "watchdog");
    end

    initial begin
        int     x[$];
        longint t0, t;
        int     n;

        repeat (3) @(negedge clk_tr);
        chk("rst_rdy_work1", col_in_rdy, 1);
        dwt_work = 1'b0;
        #1;
        chk("rst_rdy_work0", col_in_rdy, 0);
        dwt_work = 1'b1;
        @(negedge clk_tr);
        rst = 1'b0;

        // Constant column with latency and ready-gap checks.
        x = '{100, 100, 100, 100, 100, 100, 100, 100};
        emit_t.delete();
        send_col(x, 0, t0);
        chk("flush_rdy_low", col_in_rdy, 0);
        @(posedge clk_tr);
        #1;
        chk("idle_rdy_high", col_in_rdy, 1);
        @(posedge clk_tr);
        #2;
        chk("const_emit_count", emit_t.size(), 4);
        for (int i = 0; i < 4 && i < emit_t.size(); i++)
            chk("const_emit_time", int'(emit_t[i] - t0), 10 * (i + 1));
        wait_drain();

        x = '{0, 1, 2, 3, 4, 5, 6, 7};
        send_col(x, 0, t0);
        wait_drain();

        x = '{10, 4};
        emit_t.delete();
        send_col(x, 0, t0);
        chk("single_flush_rdy", col_in_rdy, 0);
        @(posedge clk_tr);
        #2;
        chk("single_emit_count", emit_t.size(), 1);
        if (emit_t.size() == 1) chk("single_emit_time", int'(emit_t[0] - t0), 10);
        wait_drain();

        // Ramp with stalls after pair 1 and during FLUSH.
        x = '{0, 1, 2, 3, 4, 5, 6, 7};
        push_col(x, 4);
        send_pair(0, 1, 1'b0, t);
        send_pair(2, 3, 1'b0, t);
        @(negedge clk_tr);
        dwt_work = 1'b0;
        repeat (3) @(negedge clk_tr);
        dwt_work = 1'b1;
        send_pair(4, 5, 1'b0, t);
        send_pair(6, 7, 1'b1, t);
        @(negedge clk_tr);
        dwt_work = 1'b0;
        repeat (2) @(negedge clk_tr);
        dwt_work = 1'b1;
        wait_drain();

        x = '{32767, -32768, 32767, -32768};
        send_col(x, 0, t0);
        wait_drain();

        // Reset mid-column; the pair shown during reset must be ignored.
        x = '{5, 9, 13, 2};
        push_col(x, 1);
        send_pair(5, 9, 1'b0, t);
        send_pair(13, 2, 1'b0, t);
        @(negedge clk_tr);
        rst         = 1'b1;
        col_in_even = 16'(7);
        col_in_odd  = 16'(7);
        col_in_vld  = 1'b1;
        @(negedge clk_tr);
        rst        = 1'b0;
        col_in_vld = 1'b0;
        wait_drain();
        x = '{0, 1, 2, 3};
        send_col(x, 0, t0);
        wait_drain();

        // Randomized columns with random gaps and enable stalls.
        stall_en = 1'b1;
        for (int c = 0; c < 40; c++) begin
            n = $urandom_range(1, 6);
            x.delete();
            for (int i = 0; i < 2 * n; i++)
                x.push_back(int'($signed(16'($urandom))));
            send_col(x, 2, t0);
        end
        @(negedge clk_tr);
        stall_en = 1'b0;
        dwt_work = 1'b1;
        wait_drain();

        repeat (3) @(negedge clk_tr);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
